// File: rtl/peripheral_axi4_pkg.sv
// peripheral_axi4_pkg
// Shared definitions for the two-master AXI4 arbiter: default field widths,
// write/read FSM state encodings, AXI burst/response codes and a handshake
// helper. Imported by the interface, the arbiter core and the bench.
package peripheral_axi4_pkg;

  localparam int AXI_ID_WIDTH_DEF   = 8;
  localparam int AXI_ADDR_WIDTH_DEF = 64;
  localparam int AXI_DATA_WIDTH_DEF = 64;
  localparam int AXI_STRB_WIDTH_DEF = AXI_DATA_WIDTH_DEF / 8;
  localparam int AXI_USER_WIDTH_DEF = 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // A transfer completes on a rising edge where valid and ready are both 1.
  function automatic logic axi_hs(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/peripheral_axi4_arbiter_if.sv
// peripheral_axi4_arbiter_if
// One full AXI4 port (AW, W, B, AR, R channels).
// Handshake rule for every channel: the source raises valid with stable
// payload and holds both until the sink's ready is seen high on a rising edge;
// ready may be raised or lowered freely and never waits on an edge by itself.
// Modports:
//   master - drives AW/W/AR payload+valid, B/R ready; receives the rest.
//   slave  - the mirror image.
interface peripheral_axi4_arbiter_if #(
  parameter int ID_W   = peripheral_axi4_pkg::AXI_ID_WIDTH_DEF,
  parameter int ADDR_W = peripheral_axi4_pkg::AXI_ADDR_WIDTH_DEF,
  parameter int DATA_W = peripheral_axi4_pkg::AXI_DATA_WIDTH_DEF,
  parameter int STRB_W = peripheral_axi4_pkg::AXI_STRB_WIDTH_DEF,
  parameter int USER_W = peripheral_axi4_pkg::AXI_USER_WIDTH_DEF
);
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              aw_lock;
  logic [3:0]        aw_cache;
  logic [2:0]        aw_prot;
  logic [3:0]        aw_qos;
  logic [3:0]        aw_region;
  logic [USER_W-1:0] aw_user;
  logic              aw_valid;
  logic              aw_ready;

  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;
  logic [USER_W-1:0] w_user;
  logic              w_valid;
  logic              w_ready;

  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic [USER_W-1:0] b_user;
  logic              b_valid;
  logic              b_ready;

  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              ar_lock;
  logic [3:0]        ar_cache;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_qos;
  logic [3:0]        ar_region;
  logic [USER_W-1:0] ar_user;
  logic              ar_valid;
  logic              ar_ready;

  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [USER_W-1:0] r_user;
  logic              r_valid;
  logic              r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/peripheral_arbiter_rr.sv
// peripheral_arbiter_rr
// Two-way round-robin picker.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   req_i[1:0]   - request per master
//   en_i         - a grant is being taken this cycle if any request is up
//   gnt_o        - index of the master that would be granted now
// last_q remembers the most recent grant; it resets to 1 so that master 0
// wins the first contested round.
module peripheral_arbiter_rr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 1'b0;
    if (req_i == 2'b11) gnt_o = ~last_q;
    else if (req_i[1])  gnt_o = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                  last_q <= 1'b1;
    else if (en_i && |req_i)    last_q <= gnt_o;
  end

endmodule

// File: rtl/peripheral_axi4_arbiter.sv
// peripheral_axi4_arbiter
// Shares one AXI4 slave port between two masters. Writes and reads are owned
// by independent FSMs, each with one transaction outstanding and its own
// round-robin arbiter. Once granted, payload and handshakes are forwarded
// combinationally; only the owning master of a channel sees valid/ready.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   m0_axi, m1_axi        - upstream master ports (slave modport)
//   s_axi                 - shared downstream port (master modport)
//   wr_grant_o/rd_grant_o - index of current write/read owner
//   wr_busy_o/rd_busy_o   - write/read FSM not idle
//   wr_state_o/rd_state_o - FSM state, for observation
module peripheral_axi4_arbiter
  import peripheral_axi4_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = AXI_ID_WIDTH_DEF,
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter int AXI_STRB_WIDTH = AXI_STRB_WIDTH_DEF,
  parameter int AXI_USER_WIDTH = AXI_USER_WIDTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  peripheral_axi4_arbiter_if.slave     m0_axi,
  peripheral_axi4_arbiter_if.slave     m1_axi,
  peripheral_axi4_arbiter_if.master    s_axi,
  output logic                         wr_grant_o,
  output logic                         rd_grant_o,
  output logic                         wr_busy_o,
  output logic                         rd_busy_o,
  output wr_state_e                    wr_state_o,
  output rd_state_e                    rd_state_o
);

  wr_state_e wr_state_q;
  rd_state_e rd_state_q;
  logic      wr_grant_q, rd_grant_q;
  logic      wr_busy_q, rd_busy_q;
  logic      wr_arb_gnt, rd_arb_gnt;
  logic [1:0] wr_req, rd_req;

  assign wr_req = {m1_axi.aw_valid, m0_axi.aw_valid};
  assign rd_req = {m1_axi.ar_valid, m0_axi.ar_valid};

  // Channel ownership. Masked by rst_i so that nothing handshakes in the
  // cycle a reset lands mid-transfer.
  logic wr_addr_ph, wr_data_ph, wr_resp_ph, rd_addr_ph, rd_data_ph;
  assign wr_addr_ph = ~rst_i && (wr_state_q == W_ADDR);
  assign wr_data_ph = ~rst_i && (wr_state_q == W_DATA);
  assign wr_resp_ph = ~rst_i && (wr_state_q == W_RESP);
  assign rd_addr_ph = ~rst_i && (rd_state_q == R_ADDR);
  assign rd_data_ph = ~rst_i && (rd_state_q == R_DATA);

  peripheral_arbiter_rr u_wr_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (wr_req),
    .en_i  (wr_state_q == W_IDLE),
    .gnt_o (wr_arb_gnt)
  );

  peripheral_arbiter_rr u_rd_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (rd_req),
    .en_i  (rd_state_q == R_IDLE),
    .gnt_o (rd_arb_gnt)
  );

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      wr_grant_q <= 1'b0;
      wr_busy_q  <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (|wr_req) begin
          wr_state_q <= W_ADDR;
          wr_grant_q <= wr_arb_gnt;
          wr_busy_q  <= 1'b1;
        end
        W_ADDR: if (axi_hs(s_axi.aw_valid, s_axi.aw_ready)) wr_state_q <= W_DATA;
        W_DATA: if (axi_hs(s_axi.w_valid, s_axi.w_ready) && s_axi.w_last)
          wr_state_q <= W_RESP;
        W_RESP: if (axi_hs(s_axi.b_valid, s_axi.b_ready)) begin
          wr_state_q <= W_IDLE;
          wr_busy_q  <= 1'b0;
        end
        default: begin
          wr_state_q <= W_IDLE;
          wr_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rd_grant_q <= 1'b0;
      rd_busy_q  <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (|rd_req) begin
          rd_state_q <= R_ADDR;
          rd_grant_q <= rd_arb_gnt;
          rd_busy_q  <= 1'b1;
        end
        R_ADDR: if (axi_hs(s_axi.ar_valid, s_axi.ar_ready)) rd_state_q <= R_DATA;
        R_DATA: if (axi_hs(s_axi.r_valid, s_axi.r_ready) && s_axi.r_last) begin
          rd_state_q <= R_IDLE;
          rd_busy_q  <= 1'b0;
        end
        default: begin
          rd_state_q <= R_IDLE;
          rd_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_grant_o = wr_grant_q;
  assign rd_grant_o = rd_grant_q;
  assign wr_busy_o  = wr_busy_q;
  assign rd_busy_o  = rd_busy_q;
  assign wr_state_o = wr_state_q;
  assign rd_state_o = rd_state_q;

  // ---------------- AW ----------------
  logic [AXI_ID_WIDTH-1:0]   aw_id_sel, ar_id_sel;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_sel, ar_addr_sel;
  logic [AXI_USER_WIDTH-1:0] aw_user_sel, ar_user_sel, w_user_sel;
  logic [AXI_DATA_WIDTH-1:0] w_data_sel;
  logic [AXI_STRB_WIDTH-1:0] w_strb_sel;

  assign aw_id_sel   = wr_grant_q ? m1_axi.aw_id   : m0_axi.aw_id;
  assign aw_addr_sel = wr_grant_q ? m1_axi.aw_addr : m0_axi.aw_addr;
  assign aw_user_sel = wr_grant_q ? m1_axi.aw_user : m0_axi.aw_user;

  assign s_axi.aw_id     = aw_id_sel;
  assign s_axi.aw_addr   = aw_addr_sel;
  assign s_axi.aw_user   = aw_user_sel;
  assign s_axi.aw_len    = wr_grant_q ? m1_axi.aw_len    : m0_axi.aw_len;
  assign s_axi.aw_size   = wr_grant_q ? m1_axi.aw_size   : m0_axi.aw_size;
  assign s_axi.aw_burst  = wr_grant_q ? m1_axi.aw_burst  : m0_axi.aw_burst;
  assign s_axi.aw_lock   = wr_grant_q ? m1_axi.aw_lock   : m0_axi.aw_lock;
  assign s_axi.aw_cache  = wr_grant_q ? m1_axi.aw_cache  : m0_axi.aw_cache;
  assign s_axi.aw_prot   = wr_grant_q ? m1_axi.aw_prot   : m0_axi.aw_prot;
  assign s_axi.aw_qos    = wr_grant_q ? m1_axi.aw_qos    : m0_axi.aw_qos;
  assign s_axi.aw_region = wr_grant_q ? m1_axi.aw_region : m0_axi.aw_region;
  assign s_axi.aw_valid  = wr_addr_ph & (wr_grant_q ? m1_axi.aw_valid : m0_axi.aw_valid);
  assign m0_axi.aw_ready = wr_addr_ph & ~wr_grant_q & s_axi.aw_ready;
  assign m1_axi.aw_ready = wr_addr_ph &  wr_grant_q & s_axi.aw_ready;

  // ---------------- W (only after AW is accepted) ----------------
  assign w_data_sel = wr_grant_q ? m1_axi.w_data : m0_axi.w_data;
  assign w_strb_sel = wr_grant_q ? m1_axi.w_strb : m0_axi.w_strb;
  assign w_user_sel = wr_grant_q ? m1_axi.w_user : m0_axi.w_user;

  assign s_axi.w_data   = w_data_sel;
  assign s_axi.w_strb   = w_strb_sel;
  assign s_axi.w_user   = w_user_sel;
  assign s_axi.w_last   = wr_grant_q ? m1_axi.w_last : m0_axi.w_last;
  assign s_axi.w_valid  = wr_data_ph & (wr_grant_q ? m1_axi.w_valid : m0_axi.w_valid);
  assign m0_axi.w_ready = wr_data_ph & ~wr_grant_q & s_axi.w_ready;
  assign m1_axi.w_ready = wr_data_ph &  wr_grant_q & s_axi.w_ready;

  // ---------------- B (payload broadcast, valid steered) ----------------
  assign m0_axi.b_id    = s_axi.b_id;
  assign m0_axi.b_resp  = s_axi.b_resp;
  assign m0_axi.b_user  = s_axi.b_user;
  assign m1_axi.b_id    = s_axi.b_id;
  assign m1_axi.b_resp  = s_axi.b_resp;
  assign m1_axi.b_user  = s_axi.b_user;
  assign m0_axi.b_valid = wr_resp_ph & ~wr_grant_q & s_axi.b_valid;
  assign m1_axi.b_valid = wr_resp_ph &  wr_grant_q & s_axi.b_valid;
  assign s_axi.b_ready  = wr_resp_ph & (wr_grant_q ? m1_axi.b_ready : m0_axi.b_ready);

  // ---------------- AR ----------------
  assign ar_id_sel   = rd_grant_q ? m1_axi.ar_id   : m0_axi.ar_id;
  assign ar_addr_sel = rd_grant_q ? m1_axi.ar_addr : m0_axi.ar_addr;
  assign ar_user_sel = rd_grant_q ? m1_axi.ar_user : m0_axi.ar_user;

  assign s_axi.ar_id     = ar_id_sel;
  assign s_axi.ar_addr   = ar_addr_sel;
  assign s_axi.ar_user   = ar_user_sel;
  assign s_axi.ar_len    = rd_grant_q ? m1_axi.ar_len    : m0_axi.ar_len;
  assign s_axi.ar_size   = rd_grant_q ? m1_axi.ar_size   : m0_axi.ar_size;
  assign s_axi.ar_burst  = rd_grant_q ? m1_axi.ar_burst  : m0_axi.ar_burst;
  assign s_axi.ar_lock   = rd_grant_q ? m1_axi.ar_lock   : m0_axi.ar_lock;
  assign s_axi.ar_cache  = rd_grant_q ? m1_axi.ar_cache  : m0_axi.ar_cache;
  assign s_axi.ar_prot   = rd_grant_q ? m1_axi.ar_prot   : m0_axi.ar_prot;
  assign s_axi.ar_qos    = rd_grant_q ? m1_axi.ar_qos    : m0_axi.ar_qos;
  assign s_axi.ar_region = rd_grant_q ? m1_axi.ar_region : m0_axi.ar_region;
  assign s_axi.ar_valid  = rd_addr_ph & (rd_grant_q ? m1_axi.ar_valid : m0_axi.ar_valid);
  assign m0_axi.ar_ready = rd_addr_ph & ~rd_grant_q & s_axi.ar_ready;
  assign m1_axi.ar_ready = rd_addr_ph &  rd_grant_q & s_axi.ar_ready;

  // ---------------- R (payload broadcast, valid steered) ----------------
  assign m0_axi.r_id    = s_axi.r_id;
  assign m0_axi.r_data  = s_axi.r_data;
  assign m0_axi.r_resp  = s_axi.r_resp;
  assign m0_axi.r_last  = s_axi.r_last;
  assign m0_axi.r_user  = s_axi.r_user;
  assign m1_axi.r_id    = s_axi.r_id;
  assign m1_axi.r_data  = s_axi.r_data;
  assign m1_axi.r_resp  = s_axi.r_resp;
  assign m1_axi.r_last  = s_axi.r_last;
  assign m1_axi.r_user  = s_axi.r_user;
  assign m0_axi.r_valid = rd_data_ph & ~rd_grant_q & s_axi.r_valid;
  assign m1_axi.r_valid = rd_data_ph &  rd_grant_q & s_axi.r_valid;
  assign s_axi.r_ready  = rd_data_ph & (rd_grant_q ? m1_axi.r_ready : m0_axi.r_ready);

endmodule

// File: tb/tb_peripheral_axi4_arbiter.sv
// Directed bench for peripheral_axi4_arbiter. Inputs change 2 time units
// after a rising edge and outputs are compared 1 unit later.
module tb_peripheral_axi4_arbiter;
  import peripheral_axi4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  peripheral_axi4_arbiter_if m_if [2] ();
  peripheral_axi4_arbiter_if s_if ();

  logic      wr_grant, rd_grant, wr_busy, rd_busy;
  wr_state_e wr_state;
  rd_state_e rd_state;

  peripheral_axi4_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0_axi     (m_if[0]),
    .m1_axi     (m_if[1]),
    .s_axi      (s_if),
    .wr_grant_o (wr_grant),
    .rd_grant_o (rd_grant),
    .wr_busy_o  (wr_busy),
    .rd_busy_o  (rd_busy),
    .wr_state_o (wr_state),
    .rd_state_o (rd_state)
  );

  // Per-master drive/observe arrays so tasks can index a master at run time.
  logic        m_aw_valid [2], m_w_valid [2], m_w_last [2], m_b_ready [2];
  logic        m_ar_valid [2], m_r_ready [2];
  logic [7:0]  m_aw_len [2], m_ar_len [2];
  logic [63:0] m_w_data [2];
  logic        m_aw_ready [2], m_w_ready [2], m_b_valid [2], m_ar_ready [2], m_r_valid [2];
  logic [7:0]  m_b_id [2];
  logic [1:0]  m_b_resp [2];
  logic [63:0] m_r_data [2];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign m_if[g].aw_id     = 8'(16 + g);
    assign m_if[g].aw_addr   = 64'(32'h1000 + 256 * g);
    assign m_if[g].aw_len    = m_aw_len[g];
    assign m_if[g].aw_size   = 3'd3;
    assign m_if[g].aw_burst  = AXI_BURST_INCR;
    assign m_if[g].aw_lock   = 1'b0;
    assign m_if[g].aw_cache  = 4'h3;
    assign m_if[g].aw_prot   = 3'd0;
    assign m_if[g].aw_qos    = 4'd0;
    assign m_if[g].aw_region = 4'd0;
    assign m_if[g].aw_user   = 8'(g + 1);
    assign m_if[g].aw_valid  = m_aw_valid[g];
    assign m_if[g].w_data    = m_w_data[g];
    assign m_if[g].w_strb    = 8'hFF;
    assign m_if[g].w_last    = m_w_last[g];
    assign m_if[g].w_user    = 8'(g);
    assign m_if[g].w_valid   = m_w_valid[g];
    assign m_if[g].b_ready   = m_b_ready[g];
    assign m_if[g].ar_id     = 8'(32 + g);
    assign m_if[g].ar_addr   = 64'(32'h2000 + 256 * g);
    assign m_if[g].ar_len    = m_ar_len[g];
    assign m_if[g].ar_size   = 3'd3;
    assign m_if[g].ar_burst  = AXI_BURST_INCR;
    assign m_if[g].ar_lock   = 1'b0;
    assign m_if[g].ar_cache  = 4'h0;
    assign m_if[g].ar_prot   = 3'd0;
    assign m_if[g].ar_qos    = 4'd0;
    assign m_if[g].ar_region = 4'd0;
    assign m_if[g].ar_user   = 8'd0;
    assign m_if[g].ar_valid  = m_ar_valid[g];
    assign m_if[g].r_ready   = m_r_ready[g];
    assign m_aw_ready[g] = m_if[g].aw_ready;
    assign m_w_ready[g]  = m_if[g].w_ready;
    assign m_b_valid[g]  = m_if[g].b_valid;
    assign m_b_id[g]     = m_if[g].b_id;
    assign m_b_resp[g]   = m_if[g].b_resp;
    assign m_ar_ready[g] = m_if[g].ar_ready;
    assign m_r_valid[g]  = m_if[g].r_valid;
    assign m_r_data[g]   = m_if[g].r_data;
  end

  // ---------------- scoreboard counters / checker ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      m_aw_valid[k] = 1'b0; m_w_valid[k] = 1'b0; m_w_last[k] = 1'b0;
      m_b_ready[k]  = 1'b0; m_ar_valid[k] = 1'b0; m_r_ready[k] = 1'b0;
      m_aw_len[k]   = 8'd0; m_ar_len[k]  = 8'd0; m_w_data[k] = 64'd0;
    end
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1; s_if.ar_ready = 1'b1;
    s_if.b_valid  = 1'b0; s_if.b_id = 8'd0; s_if.b_resp = 2'd0; s_if.b_user = 8'd0;
    s_if.r_valid  = 1'b0; s_if.r_id = 8'd0; s_if.r_data = 64'd0;
    s_if.r_resp   = 2'd0; s_if.r_last = 1'b0; s_if.r_user = 8'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Entered in a W_ADDR cycle owned by master k with the slave's aw_ready
  // high; runs the AW handshake, nbeats W beats and the B response.
  task automatic finish_write(input int k, input int nbeats);
    tick();
    m_aw_valid[k] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      m_w_valid[k] = 1'b1;
      m_w_data[k]  = 64'hD000 + 64'(k * 16 + i);
      m_w_last[k]  = (i == nbeats - 1);
      #1;
      check("w_valid_fwd", s_if.w_valid, 1'b1);
      check("w_data_fwd", s_if.w_data, 64'hD000 + 64'(k * 16 + i));
      check("w_ready_owner", m_w_ready[k], 1'b1);
      check("w_ready_other", m_w_ready[1-k], 1'b0);
      tick();
    end
    m_w_valid[k] = 1'b0;
    m_w_last[k]  = 1'b0;
    s_if.b_valid = 1'b1;
    s_if.b_id    = 8'(16 + k);
    s_if.b_resp  = AXI_RESP_OKAY;
    m_b_ready[k] = 1'b1;
    #1;
    check("b_valid_owner", m_b_valid[k], 1'b1);
    check("b_valid_other", m_b_valid[1-k], 1'b0);
    check("b_id", m_b_id[k], 64'(16 + k));
    check("b_resp", m_b_resp[k], AXI_RESP_OKAY);
    check("s_b_ready", s_if.b_ready, 1'b1);
    tick();
    s_if.b_valid = 1'b0;
    m_b_ready[k] = 1'b0;
    #1;
    check("wr_back_idle", wr_state, W_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    tick();
    #1;
    check("rst_wr_busy", wr_busy, 1'b0);
    check("rst_rd_busy", rd_busy, 1'b0);
    check("rst_wr_grant", wr_grant, 1'b0);
    check("rst_rd_grant", rd_grant, 1'b0);
    check("rst_s_aw_valid", s_if.aw_valid, 1'b0);
    check("rst_s_ar_valid", s_if.ar_valid, 1'b0);
    check("rst_wr_state", wr_state, W_IDLE);
    tick();
    rst = 1'b0;

    // m0 single write, len=3 to 0x1000
    m_aw_len[0]   = 8'd3;
    m_aw_valid[0] = 1'b1;
    #1;
    check("idle_no_aw", s_if.aw_valid, 1'b0);
    tick();
    m_w_valid[0] = 1'b1;
    #1;
    check("aw_latency", s_if.aw_valid, 1'b1);
    check("aw_addr", s_if.aw_addr, 64'h1000);
    check("aw_len", s_if.aw_len, 8'd3);
    check("aw_id", s_if.aw_id, 8'h10);
    check("wr_grant_m0", wr_grant, 1'b0);
    check("wr_busy_on", wr_busy, 1'b1);
    check("m0_aw_ready", m_aw_ready[0], 1'b1);
    check("m1_aw_ready", m_aw_ready[1], 1'b0);
    check("no_w_before_aw", s_if.w_valid, 1'b0);
    finish_write(0, 4);

    // simultaneous writers from reset: m0, then m1, then m0
    do_reset();
    m_aw_valid[0] = 1'b1;
    m_aw_valid[1] = 1'b1;
    tick();
    #1;
    check("rr_first", wr_grant, 1'b0);
    check("rr_first_id", s_if.aw_id, 8'h10);
    check("rr_pend_aw_ready", m_aw_ready[1], 1'b0);
    finish_write(0, 1);
    tick();
    #1;
    check("rr_second", wr_grant, 1'b1);
    check("rr_second_id", s_if.aw_id, 8'h11);
    finish_write(1, 1);
    m_aw_valid[0] = 1'b1;
    m_aw_valid[1] = 1'b1;
    s_if.aw_ready = 1'b0;
    tick();
    #1;
    check("rr_third", wr_grant, 1'b0);

    // slave stalls AW for 5 cycles
    m_w_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_state", wr_state, W_ADDR);
      check("stall_s_aw_valid", s_if.aw_valid, 1'b1);
      check("stall_m0_aw_ready", m_aw_ready[0], 1'b0);
      check("stall_m1_aw_ready", m_aw_ready[1], 1'b0);
      check("stall_no_w", s_if.w_valid, 1'b0);
      tick();
    end
    s_if.aw_ready = 1'b1;
    finish_write(0, 1);

    // m1 still pending: granted straight from IDLE, then reset mid-burst
    m_aw_len[1] = 8'd3;
    tick();
    #1;
    check("b2b_grant", wr_grant, 1'b1);
    tick();
    m_aw_valid[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_w_valid[1] = 1'b1;
      m_w_data[1]  = 64'hE000 + 64'(i);
      tick();
    end
    m_w_valid[1] = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_cycle_no_w", s_if.w_valid, 1'b0);
    check("rst_cycle_no_wready", m_w_ready[1], 1'b0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("post_rst_busy", wr_busy, 1'b0);
    check("post_rst_state", wr_state, W_IDLE);
    check("post_rst_grant", wr_grant, 1'b0);
    check("post_rst_aw_valid", s_if.aw_valid, 1'b0);
    m_aw_valid[0] = 1'b1;
    m_aw_valid[1] = 1'b1;
    tick();
    #1;
    check("post_rst_ptr_m0", wr_grant, 1'b0);
    do_reset();

    // concurrent: m0 writes 4 beats while m1 reads 8 beats
    m_aw_len[0]   = 8'd3;
    m_aw_valid[0] = 1'b1;
    m_ar_len[1]   = 8'd7;
    m_ar_valid[1] = 1'b1;
    tick();
    #1;
    check("cc_wr_grant", wr_grant, 1'b0);
    check("cc_rd_grant", rd_grant, 1'b1);
    check("cc_rd_busy", rd_busy, 1'b1);
    check("cc_ar_valid", s_if.ar_valid, 1'b1);
    check("cc_ar_id", s_if.ar_id, 8'h21);
    check("cc_ar_len", s_if.ar_len, 8'd7);
    check("cc_m1_ar_ready", m_ar_ready[1], 1'b1);
    check("cc_m0_ar_ready", m_ar_ready[0], 1'b0);
    tick();
    m_aw_valid[0] = 1'b0;
    m_ar_valid[1] = 1'b0;
    m_r_ready[1]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.r_valid = 1'b1;
      s_if.r_id    = 8'h21;
      s_if.r_data  = 64'hA000 + 64'(i);
      s_if.r_last  = (i == 7);
      if (i < 4) begin
        m_w_valid[0] = 1'b1;
        m_w_data[0]  = 64'hC000 + 64'(i);
        m_w_last[0]  = (i == 3);
      end
      if (i == 4) begin
        m_w_valid[0] = 1'b0;
        m_w_last[0]  = 1'b0;
        s_if.b_valid = 1'b1;
        s_if.b_id    = 8'h10;
        s_if.b_resp  = AXI_RESP_OKAY;
        m_b_ready[0] = 1'b1;
      end
      if (i == 5) begin
        s_if.b_valid = 1'b0;
        m_b_ready[0] = 1'b0;
      end
      #1;
      check("cc_r_valid_m1", m_r_valid[1], 1'b1);
      check("cc_r_valid_m0", m_r_valid[0], 1'b0);
      check("cc_r_data", m_r_data[1], 64'hA000 + 64'(i));
      if (i < 4) check("cc_w_data", s_if.w_data, 64'hC000 + 64'(i));
      if (i == 4) check("cc_b_valid_m0", m_b_valid[0], 1'b1);
      tick();
    end
    s_if.r_valid = 1'b0;
    s_if.r_last  = 1'b0;
    m_r_ready[1] = 1'b0;
    #1;
    check("cc_rd_done", rd_busy, 1'b0);
    check("cc_wr_done", wr_busy, 1'b0);

    // m1 read with r_ready held low for 3 cycles
    m_ar_len[1]   = 8'd1;
    m_ar_valid[1] = 1'b1;
    tick();
    tick();
    m_ar_valid[1] = 1'b0;
    s_if.r_valid  = 1'b1;
    s_if.r_data   = 64'hBEEF0;
    s_if.r_last   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_s_r_ready", s_if.r_ready, 1'b0);
      check("bp_r_valid", m_r_valid[1], 1'b1);
      check("bp_r_data", m_r_data[1], 64'hBEEF0);
      check("bp_state", rd_state, R_DATA);
      tick();
    end
    m_r_ready[1] = 1'b1;
    #1;
    check("bp_release", s_if.r_ready, 1'b1);
    tick();
    s_if.r_data = 64'hBEEF1;
    s_if.r_last = 1'b1;
    #1;
    check("bp_beat1", m_r_data[1], 64'hBEEF1);
    check("bp_beat1_state", rd_state, R_DATA);
    tick();
    s_if.r_valid = 1'b0;
    s_if.r_last  = 1'b0;
    #1;
    check("bp_done_state", rd_state, R_IDLE);
    check("bp_done_busy", rd_busy, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
